// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - padded 3x3 output buffer sequencer: bordered fill, then window read sweep
// Optional OBUF_CTRL_PAD_ONCE_EN: zero border written only by the first frame after reset.
module output_buffer_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int OUT_CHANNELS = 3,
    parameter int IN_WIDTH     = 5,
    parameter int IN_HEIGHT    = 5,
    localparam int PAD_W = IN_WIDTH + 2,
    localparam int PAD_H = IN_HEIGHT + 2,
    localparam int DEPTH = PAD_W * PAD_H * OUT_CHANNELS,
    localparam int NPIX  = IN_WIDTH * IN_HEIGHT,
    localparam int AW    = $clog2(DEPTH),
    localparam int RW    = $clog2(NPIX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic [AW-1:0]         buf_wr_addr,
    output logic                  buf_wr_en,
    output logic                  buf_is_padding,
    output logic [RW-1:0]         buf_rd_addr,
    output logic                  buf_rd_en,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CW  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int PRW = $clog2(PAD_H);
    localparam int PCW = $clog2(PAD_W);

    localparam logic [CW-1:0]  CH_LAST      = CW'(OUT_CHANNELS - 1);
    localparam logic [PCW-1:0] PC_LAST      = PCW'(PAD_W - 1);
    localparam logic [PCW-1:0] PC_LAST_INT  = PCW'(PAD_W - 2);
    localparam logic [PRW-1:0] PR_LAST      = PRW'(PAD_H - 1);
    localparam logic [AW-1:0]  WA_LAST      = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  WA_LAST_INT  = AW'(((PAD_H - 2) * PAD_W + PAD_W - 1) * OUT_CHANNELS - 1);
    localparam logic [AW-1:0]  WA_FIRST_INT = AW'((PAD_W + 1) * OUT_CHANNELS);
    localparam logic [AW-1:0]  WA_ROW_SKIP  = AW'(2 * OUT_CHANNELS + 1);
    localparam logic [RW-1:0]  RA_LAST      = RW'(NPIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_READ} state_t;

    state_t         r_state, w_state_nxt;
    logic [PRW-1:0] r_pr;
    logic [PCW-1:0] r_pc;
    logic [CW-1:0]  r_ch;
    logic [AW-1:0]  r_wa;
    logic [RW-1:0]  r_ra;
    logic           r_ra_pending;
    logic           r_win_valid;
    logic           r_done;

    logic           w_border;
    logic           w_fill_adv;
    logic           w_fill_end;
    logic           w_last_hs;
    logic           w_skip_border;
    logic [AW-1:0]  w_wa_last;

`ifdef OBUF_CTRL_PAD_ONCE_EN
    logic r_pad_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_pad_done <= 1'b0;
        else if (w_fill_end) r_pad_done <= 1'b1;
    end

    assign w_skip_border = r_pad_done;
`else
    assign w_skip_border = 1'b0;
`endif

    assign w_border  = (r_pr == '0) || (r_pr == PR_LAST) || (r_pc == '0) || (r_pc == PC_LAST);
    assign w_wa_last = w_skip_border ? WA_LAST_INT : WA_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        in_ready       = 1'b0;
        buf_wr_en      = 1'b0;
        buf_is_padding = 1'b0;
        buf_wr_addr    = '0;
        buf_rd_en      = 1'b0;
        buf_rd_addr    = '0;
        w_fill_adv     = 1'b0;
        w_fill_end     = 1'b0;
        w_last_hs      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                buf_wr_addr    = r_wa;
                buf_is_padding = w_border;
                buf_wr_en      = w_border || in_valid;
                in_ready       = !w_border;
                w_fill_adv     = w_border || in_valid;
                w_fill_end     = w_fill_adv && (r_wa == w_wa_last);
                if (w_fill_end) w_state_nxt = S_READ;
            end
            S_READ: begin
                buf_rd_addr = r_ra;
                buf_rd_en   = r_ra_pending && (!r_win_valid || win_ready);
                // With nothing left to issue, the window on display is the last one.
                w_last_hs   = r_win_valid && win_ready && !r_ra_pending;
                if (w_last_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pr         <= '0;
            r_pc         <= '0;
            r_ch         <= '0;
            r_wa         <= '0;
            r_ra         <= '0;
            r_ra_pending <= 1'b0;
            r_win_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ch         <= '0;
                    r_ra         <= '0;
                    r_ra_pending <= 1'b0;
                    r_win_valid  <= 1'b0;
                    r_pr         <= w_skip_border ? PRW'(1) : '0;
                    r_pc         <= w_skip_border ? PCW'(1) : '0;
                    r_wa         <= w_skip_border ? WA_FIRST_INT : '0;
                end
                S_FILL: begin
                    if (w_fill_end) begin
                        r_ra         <= '0;
                        r_ra_pending <= 1'b1;
                    end else if (w_fill_adv) begin
                        if (r_ch != CH_LAST) begin
                            r_ch <= r_ch + CW'(1);
                            r_wa <= r_wa + AW'(1);
                        end else if (w_skip_border && (r_pc == PC_LAST_INT)) begin
                            // Jump over the right border of this row and the left border of the next.
                            r_ch <= '0;
                            r_pc <= PCW'(1);
                            r_pr <= r_pr + PRW'(1);
                            r_wa <= r_wa + WA_ROW_SKIP;
                        end else if (r_pc == PC_LAST) begin
                            r_ch <= '0;
                            r_pc <= '0;
                            r_pr <= r_pr + PRW'(1);
                            r_wa <= r_wa + AW'(1);
                        end else begin
                            r_ch <= '0;
                            r_pc <= r_pc + PCW'(1);
                            r_wa <= r_wa + AW'(1);
                        end
                    end
                end
                S_READ: begin
                    if (buf_rd_en) begin
                        if (r_ra == RA_LAST) r_ra_pending <= 1'b0;
                        else                 r_ra         <= r_ra + RW'(1);
                    end
                    if (buf_rd_en)      r_win_valid <= 1'b1;
                    else if (win_ready) r_win_valid <= 1'b0;
                end
                default: begin
                    r_ra_pending <= 1'b0;
                    r_win_valid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= w_last_hs;
    end

    assign buf_wr_data = in_data;
    assign win_valid   = r_win_valid;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// tb/tb_output_buffer_ctrl.sv - randomized self-checking bench for output_buffer_ctrl
module tb_output_buffer_ctrl;

    localparam int DW = 8, OC = 3, IW = 5, IH = 5;
    localparam int PW = IW + 2, PH = IH + 2;
    localparam int DEPTH = PW * PH * OC, NPIX = IW * IH, NIN = NPIX * OC;
    localparam int AW = $clog2(DEPTH), RW = $clog2(NPIX);
`ifdef OBUF_CTRL_PAD_ONCE_EN
    localparam bit PAD_ONCE = 1'b1;
`else
    localparam bit PAD_ONCE = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, win_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, buf_wr_en, buf_is_padding, buf_rd_en, win_valid, busy, done;
    logic [DW-1:0] buf_wr_data;
    logic [AW-1:0] buf_wr_addr;
    logic [RW-1:0] buf_rd_addr;

    output_buffer_ctrl #(.DATA_WIDTH(DW), .OUT_CHANNELS(OC), .IN_WIDTH(IW), .IN_HEIGHT(IH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .buf_wr_data(buf_wr_data), .buf_wr_addr(buf_wr_addr),
        .buf_wr_en(buf_wr_en), .buf_is_padding(buf_is_padding), .buf_rd_addr(buf_rd_addr),
        .buf_rd_en(buf_rd_en), .win_valid(win_valid), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int base;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] frame [NIN];
    logic [DW-1:0] ref_img [PH][PW][OC];
    int exp_addr [$];
    bit exp_pad [$];
    logic [AW+RW+6:0] outs;

    int n_wr, addr_err, data_err, pad_cnt, int_cnt, pad_gap_err, first_wr_rel, first_wr_addr, last_wr_rel;
    int n_rd, rd_err, first_rd_rel, last_rd_rel, latched;
    int n_hs, hs_err, content_err, zero_err, first_hs_rel, last_hs_rel, hs7_rel, hs8_rel;
    int done_cnt, done_rel, busy_at_done, busy_at_1, bp_viol, stall_cycles, stall_err, timeout;

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hAA;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one frame from IDLE and records what the controller did against a frame-level model.
    task automatic run_frame(input int vmode, input bit rrand, input bit stall, input bit spur, input bit skip);
        int idx, rel, stall_left, tail, c, r, col, a;
        bit bd, stalling;
        for (int i = 0; i < NIN; i++) frame[i] = DW'($urandom);
        exp_addr.delete(); exp_pad.delete();
        for (int pr = 0; pr < PH; pr++)
            for (int pc = 0; pc < PW; pc++)
                for (int ch = 0; ch < OC; ch++) begin
                    bd = (pr == 0) || (pr == PH - 1) || (pc == 0) || (pc == PW - 1);
                    ref_img[pr][pc][ch] = bd ? '0 : frame[((pr - 1) * IW + (pc - 1)) * OC + ch];
                    if (!(bd && skip)) begin
                        exp_addr.push_back((pr * PW + pc) * OC + ch);
                        exp_pad.push_back(bd);
                    end
                end
        n_wr = 0; addr_err = 0; data_err = 0; pad_cnt = 0; int_cnt = 0; pad_gap_err = 0;
        first_wr_rel = -1; first_wr_addr = -1; last_wr_rel = -1;
        n_rd = 0; rd_err = 0; first_rd_rel = -1; last_rd_rel = -1; latched = -1;
        n_hs = 0; hs_err = 0; content_err = 0; zero_err = 0; first_hs_rel = -1; last_hs_rel = -1;
        hs7_rel = -1; hs8_rel = -1; done_cnt = 0; done_rel = -1; busy_at_done = -1; busy_at_1 = -1;
        bp_viol = 0; stall_cycles = 0; stall_err = 0;
        idx = 0; stall_left = stall ? 10 : 0; tail = -1;
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1; base = cyc;
        for (int t = 0; t < 3000 && tail != 0; t++) begin
            @(posedge clk); #1;
            rel = cyc - base;
            start = spur && (rel == 50 || rel == 160);
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (rel % 2) == 1;
                default: in_valid = ($urandom_range(0, 1) == 1);
            endcase
            in_data = (idx < NIN) ? frame[idx] : '0;
            stalling = 1'b0;
            if (stall_left > 0 && n_hs == 7) begin
                win_ready = 1'b0; stalling = 1'b1; stall_left--;
            end else if (rrand) win_ready = ($urandom_range(0, 3) != 0);
            else win_ready = 1'b1;
            @(negedge clk);
            if (rel == 1) busy_at_1 = busy;
            if (in_valid && in_ready) idx++;
            if (buf_wr_en === 1'b1) begin
                if (n_wr == 0) begin first_wr_rel = rel; first_wr_addr = buf_wr_addr; end
                if (buf_is_padding && n_wr > 0 && rel != last_wr_rel + 1) pad_gap_err++;
                if (n_wr >= exp_addr.size()) addr_err++;
                else if (buf_wr_addr !== AW'(exp_addr[n_wr]) || buf_is_padding !== exp_pad[n_wr]) addr_err++;
                if (buf_is_padding) begin
                    pad_cnt++;
                    if (buf_wr_addr < DEPTH) mem[buf_wr_addr] = '0;
                end else begin
                    if (int_cnt >= NIN || buf_wr_data !== frame[int_cnt]) data_err++;
                    int_cnt++;
                    if (buf_wr_addr < DEPTH) mem[buf_wr_addr] = buf_wr_data;
                end
                last_wr_rel = rel; n_wr++;
            end
            if (win_valid && !win_ready && buf_rd_en) bp_viol++;
            if (stalling) begin
                stall_cycles++;
                if (buf_rd_en !== 1'b0 || buf_rd_addr !== RW'(8) || win_valid !== 1'b1 || latched != 7) stall_err++;
            end
            if (win_valid === 1'b1 && win_ready) begin
                if (n_hs == 0) first_hs_rel = rel;
                if (n_hs == 7) hs7_rel = rel;
                if (n_hs == 8) hs8_rel = rel;
                last_hs_rel = rel;
                if (latched != n_hs || latched < 0) hs_err++;
                else begin
                    c = latched; r = c / IW; col = c % IW;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            for (int ch = 0; ch < OC; ch++) begin
                                a = ((r + dr) * PW + col + dc) * OC + ch;
                                if (mem[a] !== ref_img[r + dr][col + dc][ch]) content_err++;
                                if (n_hs == 0 && (dr == 0 || dc == 0) && mem[a] !== '0) zero_err++;
                            end
                end
                n_hs++;
            end
            if (buf_rd_en === 1'b1) begin
                if (n_rd == 0) first_rd_rel = rel;
                last_rd_rel = rel;
                if (buf_rd_addr !== RW'(n_rd)) rd_err++;
                latched = buf_rd_addr;
                n_rd++;
            end
            if (done === 1'b1) begin
                if (done_cnt == 0) begin done_rel = rel; busy_at_done = busy; tail = 3; end
                done_cnt++;
            end
            if (tail > 0) tail--;
        end
        timeout = (tail != 0);
        start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        outs = {in_ready, buf_wr_en, buf_is_padding, buf_wr_addr, buf_rd_en, buf_rd_addr, win_valid, busy, done};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        do_reset();
        run_frame(0, 0, 0, 0, 0);
        checks++; if (timeout != 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
        checks++; if (busy_at_1 != 1) begin errors++; $display("FAIL basic_busy_fill: got %0d expected 1", busy_at_1); end
        checks++; if (first_wr_rel != 1) begin errors++; $display("FAIL basic_first_wr: got %0d expected 1", first_wr_rel); end
        checks++; if (last_wr_rel != 147) begin errors++; $display("FAIL basic_last_wr: got %0d expected 147", last_wr_rel); end
        checks++; if (n_wr != 147) begin errors++; $display("FAIL basic_n_wr: got %0d expected 147", n_wr); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL basic_wr_seq: got %0d bad expected 0", addr_err); end
        checks++; if (pad_cnt != 72) begin errors++; $display("FAIL basic_pad_cnt: got %0d expected 72", pad_cnt); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL basic_wr_data: got %0d bad expected 0", data_err); end
        checks++; if (first_rd_rel != 148 || last_rd_rel != 172) begin errors++; $display("FAIL basic_rd_window: got %0d..%0d expected 148..172", first_rd_rel, last_rd_rel); end
        checks++; if (n_rd != 25 || rd_err != 0) begin errors++; $display("FAIL basic_rd_seq: got %0d reads %0d bad expected 25 reads 0 bad", n_rd, rd_err); end
        checks++; if (first_hs_rel != 149 || last_hs_rel != 173) begin errors++; $display("FAIL basic_win_valid: got %0d..%0d expected 149..173", first_hs_rel, last_hs_rel); end
        checks++; if (n_hs != 25 || hs_err != 0) begin errors++; $display("FAIL basic_hs: got %0d windows %0d bad expected 25 0", n_hs, hs_err); end
        checks++; if (content_err != 0) begin errors++; $display("FAIL basic_content: got %0d bad expected 0", content_err); end
        checks++; if (zero_err != 0) begin errors++; $display("FAIL basic_win0_zero: got %0d bad expected 0", zero_err); end
        checks++; if (done_rel != 174 || done_cnt != 1) begin errors++; $display("FAIL basic_done: got rel %0d count %0d expected 174 1", done_rel, done_cnt); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL basic_busy_done: got %0d expected 0", busy_at_done); end
    endtask

    task automatic test_toggle_valid();
        do_reset();
        run_frame(1, 0, 0, 0, 0);
        checks++; if (timeout != 0) begin errors++; $display("FAIL toggle_timeout: got %0d expected 0", timeout); end
        checks++; if (n_wr != 147 || addr_err != 0) begin errors++; $display("FAIL toggle_wr_seq: got %0d writes %0d bad expected 147 0", n_wr, addr_err); end
        checks++; if (int_cnt != 75) begin errors++; $display("FAIL toggle_interior: got %0d expected 75", int_cnt); end
        checks++; if (pad_gap_err != 0) begin errors++; $display("FAIL toggle_pad_rate: got %0d gaps expected 0", pad_gap_err); end
        checks++; if (data_err != 0 || content_err != 0) begin errors++; $display("FAIL toggle_data: got %0d/%0d bad expected 0/0", data_err, content_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL toggle_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            do_reset();
            run_frame(2, 1, 0, 0, 0);
            checks++; if (timeout != 0) begin errors++; $display("FAIL random_timeout: got %0d expected 0", timeout); end
            checks++; if (n_wr != 147 || addr_err != 0 || data_err != 0) begin errors++; $display("FAIL random_wr: got %0d writes %0d/%0d bad expected 147 0/0", n_wr, addr_err, data_err); end
            checks++; if (n_hs != 25 || hs_err != 0 || content_err != 0) begin errors++; $display("FAIL random_win: got %0d windows %0d/%0d bad expected 25 0/0", n_hs, hs_err, content_err); end
            checks++; if (bp_viol != 0) begin errors++; $display("FAIL random_backpressure: got %0d reads under stall expected 0", bp_viol); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_frame(0, 0, 1, 0, 0);
        checks++; if (stall_cycles != 10) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 10", stall_cycles); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", stall_err); end
        checks++; if (hs8_rel != hs7_rel + 1) begin errors++; $display("FAIL bp_next_window: got %0d expected %0d", hs8_rel, hs7_rel + 1); end
        checks++; if (content_err != 0 || hs_err != 0) begin errors++; $display("FAIL bp_content: got %0d/%0d bad expected 0/0", content_err, hs_err); end
        checks++; if (done_rel != 184) begin errors++; $display("FAIL bp_done: got %0d expected 184", done_rel); end
    endtask

    task automatic test_reset_mid_fill();
        bit hit;
        do_reset();
        hit = 1'b0;
        start = 1'b1;
        for (int t = 0; t < 300 && !hit; t++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_data = DW'($urandom);
            @(negedge clk);
            if (buf_wr_en === 1'b1 && buf_wr_addr === AW'(60)) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach60: got %0d expected 1", hit); end
        #3 rst_n = 1'b0;
        #1;
        outs = {in_ready, buf_wr_en, buf_is_padding, buf_wr_addr, buf_rd_en, buf_rd_addr, win_valid, busy, done};
        checks++; if (outs !== '0) begin errors++; $display("FAIL midrst_async_outputs: got %h expected 0", outs); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, 0, 0, 0, 0);
        checks++; if (first_wr_addr != 0 || first_wr_rel != 1) begin errors++; $display("FAIL midrst_restart: got addr %0d rel %0d expected 0 1", first_wr_addr, first_wr_rel); end
        checks++; if (last_wr_rel != 147 || addr_err != 0) begin errors++; $display("FAIL midrst_fill: got %0d %0d bad expected 147 0", last_wr_rel, addr_err); end
        checks++; if (done_rel != 174 || content_err != 0) begin errors++; $display("FAIL midrst_frame: got done %0d %0d bad expected 174 0", done_rel, content_err); end
    endtask

    task automatic test_spurious_start();
        do_reset();
        run_frame(0, 0, 0, 1, 0);
        checks++; if (n_wr != 147 || addr_err != 0) begin errors++; $display("FAIL spur_wr: got %0d writes %0d bad expected 147 0", n_wr, addr_err); end
        checks++; if (done_cnt != 1 || done_rel != 174) begin errors++; $display("FAIL spur_done: got count %0d rel %0d expected 1 174", done_cnt, done_rel); end
        run_frame(0, 0, 0, 0, PAD_ONCE);
        checks++; if (last_wr_rel != (PAD_ONCE ? 75 : 147)) begin errors++; $display("FAIL second_fill: got %0d expected %0d", last_wr_rel, PAD_ONCE ? 75 : 147); end
        checks++; if (done_rel != (PAD_ONCE ? 102 : 174)) begin errors++; $display("FAIL second_done: got %0d expected %0d", done_rel, PAD_ONCE ? 102 : 174); end
        checks++; if (content_err != 0 || addr_err != 0) begin errors++; $display("FAIL second_content: got %0d/%0d bad expected 0/0", content_err, addr_err); end
    endtask

    task automatic test_pad_once();
        do_reset();
        run_frame(0, 0, 0, 0, 0);
        checks++; if (last_wr_rel != 147 || pad_cnt != 72) begin errors++; $display("FAIL pad1_fill: got %0d cycles %0d pads expected 147 72", last_wr_rel, pad_cnt); end
        run_frame(0, 0, 0, 0, PAD_ONCE);
        checks++; if (last_wr_rel != (PAD_ONCE ? 75 : 147)) begin errors++; $display("FAIL pad2_fill: got %0d expected %0d", last_wr_rel, PAD_ONCE ? 75 : 147); end
        checks++; if (pad_cnt != (PAD_ONCE ? 0 : 72)) begin errors++; $display("FAIL pad2_pad_cnt: got %0d expected %0d", pad_cnt, PAD_ONCE ? 0 : 72); end
        checks++; if (addr_err != 0 || n_wr != (PAD_ONCE ? 75 : 147)) begin errors++; $display("FAIL pad2_wr_seq: got %0d writes %0d bad", n_wr, addr_err); end
        checks++; if (zero_err != 0 || content_err != 0) begin errors++; $display("FAIL pad2_border_zero: got %0d/%0d bad expected 0/0", zero_err, content_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_random();
        test_backpressure();
        test_reset_mid_fill();
        test_spurious_start();
        test_pad_once();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
